// File: rtl/gates_pkg.sv
// gates_pkg: shared definitions for the registered bitwise logic unit.
//   GATES_NUM_FUNCS : number of result functions produced
//   GATES_MAX_W     : widest legal operand width
//   gate_fn_e       : function index used by benches and debug views
//   gate_ref()      : reference result of one function on two operands
//                     (full GATES_MAX_W bits; caller masks to its width)
package gates_pkg;

  localparam int GATES_NUM_FUNCS = 5;
  localparam int GATES_MAX_W     = 64;

  typedef enum logic [2:0] {
    FN_AND  = 3'd0,
    FN_OR   = 3'd1,
    FN_XOR  = 3'd2,
    FN_NAND = 3'd3,
    FN_NOR  = 3'd4
  } gate_fn_e;

  function automatic logic [GATES_MAX_W-1:0] gate_ref(
    input gate_fn_e               fn,
    input logic [GATES_MAX_W-1:0] a,
    input logic [GATES_MAX_W-1:0] b
  );
    logic [GATES_MAX_W-1:0] r;
    case (fn)
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      FN_NAND: r = ~(a & b);
      FN_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gates_comb.sv
// gates_comb: purely combinational five-function bitwise unit.
//   a_i, b_i   : WIDTH-bit operands
//   and_o      : a & b
//   or_o       : a | b
//   xor_o      : a ^ b
//   nand_o     : ~(a & b)
//   nor_o      : ~(a | b)
// Each bit slice sees only its own operand bits; no cross-bit terms.
module gates_comb
  import gates_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] or_o,
  output logic [WIDTH-1:0] xor_o,
  output logic [WIDTH-1:0] nand_o,
  output logic [WIDTH-1:0] nor_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_o[i]  = a_i[i] & b_i[i];
    assign or_o[i]   = a_i[i] | b_i[i];
    assign xor_o[i]  = a_i[i] ^ b_i[i];
    assign nand_o[i] = ~(a_i[i] & b_i[i]);
    assign nor_o[i]  = ~(a_i[i] | b_i[i]);
  end

endmodule

// File: rtl/gates_reg.sv
// gates_reg: registered five-function bitwise logic unit (one pipeline stage).
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (wins over in_valid)
//   in_valid  : a/b carry an operand pair this cycle
//   a, b      : WIDTH-bit operands
//   out_valid : y1..y5 were loaded at the last edge
//   y1..y5    : AND, OR, XOR, NAND, NOR of the last accepted pair
// Results hold while idle; only reset clears them.
module gates_reg
  import gates_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5
);

  logic [WIDTH-1:0] y1_d, y2_d, y3_d, y4_d, y5_d;
  logic [WIDTH-1:0] y1_q, y2_q, y3_q, y4_q, y5_q;
  // Single-stage valid shift register: vld_pipe[0] is the input side.
  logic [1:0]       vld_pipe;

  gates_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i    (a),
    .b_i    (b),
    .and_o  (y1_d),
    .or_o   (y2_d),
    .xor_o  (y3_d),
    .nand_o (y4_d),
    .nor_o  (y5_d)
  );

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
      y4_q <= '0;
      y5_q <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      // Operands are ignored when not valid, so held results stay clean.
      if (vld_pipe[0]) begin
        y1_q <= y1_d;
        y2_q <= y2_d;
        y3_q <= y3_d;
        y4_q <= y4_d;
        y5_q <= y5_d;
      end
    end
  end

  assign out_valid = vld_pipe[1];
  assign y1 = y1_q;
  assign y2 = y2_q;
  assign y3 = y3_q;
  assign y4 = y4_q;
  assign y5 = y5_q;

endmodule

// File: tb/tb_gates_reg.sv
// tb_gates_reg: directed vector table plus randomized run against a
// function-indexed reference model built on gates_pkg::gate_ref.
module tb_gates_reg;
  import gates_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic [W-1:0] y1, y2, y3, y4, y5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gates_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .y5        (y5)
  );

  typedef struct {
    logic         rst;
    logic         iv;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ev;
    logic [W-1:0] e1, e2, e3, e4, e5;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] aa, input logic [W-1:0] bb);
    rst = r; in_valid = iv; a = aa; b = bb;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: one result per function index.
  logic [W-1:0] m_y[GATES_NUM_FUNCS];
  logic         m_vld;

  task automatic model_update(input logic r, input logic iv, input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [63:0] res;
    if (r) begin
      for (int f = 0; f < GATES_NUM_FUNCS; f++) m_y[f] = '0;
      m_vld = 1'b0;
    end else begin
      m_vld = iv;
      if (iv)
        for (int f = 0; f < GATES_NUM_FUNCS; f++) begin
          res = gate_ref(gate_fn_e'(f), {{(64-W){1'b0}}, aa}, {{(64-W){1'b0}}, bb});
          m_y[f] = res[W-1:0];
        end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

    //          rst   iv    a     b     ev    y1    y2    y3    y4    y5
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
    tbl[4]  = '{1'b0, 1'b1, 4'h1, 4'h3, 1'b1, 4'h1, 4'h3, 4'h2, 4'hE, 4'hC};
    tbl[5]  = '{1'b0, 1'b1, 4'h5, 4'hA, 1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 4'hC, 4'hA, 1'b1, 4'h8, 4'hE, 4'h6, 4'h7, 4'h1};
    tbl[7]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'h8, 4'hE, 4'h6, 4'h7, 4'h1};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'h8, 4'hE, 4'h6, 4'h7, 4'h1};
    tbl[9]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'h8, 4'hE, 4'h6, 4'h7, 4'h1};
    tbl[10] = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{1'b1, 1'b1, 4'h3, 4'h5, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ev});
      check($sformatf("vec%0d y1", i), {60'd0, y1}, {60'd0, tbl[i].e1});
      check($sformatf("vec%0d y2", i), {60'd0, y2}, {60'd0, tbl[i].e2});
      check($sformatf("vec%0d y3", i), {60'd0, y3}, {60'd0, tbl[i].e3});
      check($sformatf("vec%0d y4", i), {60'd0, y4}, {60'd0, tbl[i].e4});
      check($sformatf("vec%0d y5", i), {60'd0, y5}, {60'd0, tbl[i].e5});
    end

    // Hand sequence: accept, then idle with changing operands, then reset
    // arriving alongside a valid pair must discard it.
    step(1'b0, 1'b1, 4'h9, 4'h3);
    check("seq accept y3", {60'd0, y3}, 64'hA);
    step(1'b0, 1'b0, 4'h0, 4'hF);
    step(1'b0, 1'b0, 4'hF, 4'hF);
    check("seq hold y1", {60'd0, y1}, 64'h1);
    check("seq hold y5", {60'd0, y5}, 64'h4);
    check("seq hold vld", {63'd0, out_valid}, 64'h0);
    step(1'b1, 1'b1, 4'h6, 4'h6);
    check("seq rst discard y2", {60'd0, y2}, 64'h0);
    check("seq rst discard vld", {63'd0, out_valid}, 64'h0);

    // Randomized run against the reference model.
    model_update(1'b1, 1'b0, '0, '0);
    for (int n = 0; n < 1000; n++) begin
      logic         r, iv;
      logic [W-1:0] ra, rb;
      r  = ($urandom_range(31) == 0);
      iv = $urandom_range(1);
      ra = W'($urandom);
      rb = W'($urandom);
      model_update(r, iv, ra, rb);
      step(r, iv, ra, rb);
      check("rnd out_valid", {63'd0, out_valid}, {63'd0, m_vld});
      check("rnd y1", {60'd0, y1}, {60'd0, m_y[FN_AND]});
      check("rnd y2", {60'd0, y2}, {60'd0, m_y[FN_OR]});
      check("rnd y3", {60'd0, y3}, {60'd0, m_y[FN_XOR]});
      check("rnd y4", {60'd0, y4}, {60'd0, m_y[FN_NAND]});
      check("rnd y5", {60'd0, y5}, {60'd0, m_y[FN_NOR]});
      if (out_valid) begin
        check("inv y4==~y1", {60'd0, y4}, {60'd0, ~y1});
        check("inv y5==~y2", {60'd0, y5}, {60'd0, ~y2});
        check("inv y3==y2&~y1", {60'd0, y3}, {60'd0, y2 & ~y1});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gates_reg.md
Name: gates_reg

Overview:
- Registered 5-function bitwise logic unit: AND, OR, XOR, NAND and NOR of two WIDTH-bit operands.
- Sits in the datapath as a simple pipeline stage, with a valid qualifier so downstream logic knows when results are fresh.
- Synchronous design on one clock; all outputs registered.

Parameters:
- WIDTH, 4, operand and result bit width; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  y1..y5 hold results of an accepted operand pair.
- y1  output  WIDTH  a AND b.
- y2  output  WIDTH  a OR b.
- y3  output  WIDTH  a XOR b.
- y4  output  WIDTH  NOT(a AND b).
- y5  output  WIDTH  NOT(a OR b).

Behaviour:
- Reset:
  - Reset is sampled only at the rising edge of clk and is synchronous, active-high.
  - While rst=1 at an edge: y1..y5 <= all zeros and out_valid <= 0.
  - rst has priority over in_valid in the same cycle.
- Operation:
  - At each rising edge with rst=0 and in_valid=1, all five results are computed bitwise per bit index i from a[i], b[i].
  - The results are registered simultaneously: one-cycle latency, out_valid <= 1.
- Idle:
  - At a rising edge with rst=0 and in_valid=0, y1..y5 hold their previous values and out_valid <= 0.
  - Outputs are never cleared except by reset.
- Throughput: one operand pair per cycle; back-to-back in_valid is fully supported with no bubbles.
- Bit independence: bit i of every output depends only on a[i] and b[i]; there are no carries or cross-bit terms.
- Invariants, on every registered result:
  - y4 == ~y1 and y5 == ~y2.
  - y3 == y2 & ~y1.
  - Invariants are required only when out_valid has been 1 at least once since reset. After reset all outputs are 0, so invariants do not hold until the first accepted pair.
- Combinational paths: no combinational path from any input to any output.
- X-handling: inputs are don't-care when in_valid=0 and must not disturb held outputs.
- Reset mid-stream: a result in flight (in_valid=1 in the same cycle as rst=1) is discarded. The next cycle shows zeros with out_valid=0.

Decomposition:
- Shared package gates_pkg:
  - localparam int GATES_NUM_FUNCS = 5.
  - Enum gate_fn_e {FN_AND, FN_OR, FN_XOR, FN_NAND, FN_NOR} for function indexing in benches and debug.
  - A function computing the reference result of a given gate_fn_e on two WIDTH-bit vectors, for reuse by the verification model.
- Sub-module gates_comb:
  - Purely combinational, parameterized by WIDTH.
  - Produces all five bitwise results from a and b.
  - gates_reg instantiates it and adds the registers, valid pipeline and reset.

Test Plan:
- rst=1 for 2 cycles, then a=1111, b=1111, in_valid=1 while rst still 1 -> y1..y5=0000, out_valid=0 after each of those edges.
- a=0000, b=0000, in_valid=1 -> next cycle y1=0000, y2=0000, y3=0000, y4=1111, y5=1111, out_valid=1.
- Back-to-back pairs on consecutive cycles:
  - Cycle 1: a=0001, b=0011 -> next cycle y1=0001, y2=0011, y3=0010, y4=1110, y5=1100.
  - Cycle 2: a=0101, b=1010 -> following cycle y1=0000, y2=1111, y3=1111, y4=1111, y5=0000.
  - out_valid stays 1 throughout.
- a=1100, b=1010, in_valid=1 -> y1=1000, y2=1110, y3=0110, y4=0111, y5=0001.
- Then in_valid=0 with a=1111, b=0000 for 3 cycles -> outputs stay at those values, out_valid=0.
- a=1111, b=1111, in_valid=1 -> y1=1111, y2=1111, y3=0000, y4=0000, y5=0000.
- Then rst=1 with in_valid=1 -> all outputs 0000, out_valid=0.
- Randomized 1000 cycles with random a, b, in_valid -> results match the gates_pkg model with one-cycle latency, and the invariants y4==~y1, y5==~y2 hold whenever out_valid=1.
